csel_adder_pipe: RTL

//  Parametrised, pipelined carry-select adder/subtractor for the ALU datapath.
//  The operand is split into NBLK = WIDTH/BLK equal blocks. Pipeline stage k resolves block k.

---
 rtl/csel_pkg.sv | 23 ++
 rtl/csel_adder_pipe_block.sv | 24 ++
 rtl/csel_adder_pipe.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/csel_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
// The optional signed-overflow output is enabled with the CSEL_OVF_EN macro.
package csel_pkg;

  localparam int CSEL_WIDTH_DEF = 32;
  localparam int CSEL_BLK_DEF   = 8;

  // Number of carry-select blocks, which is also the number of pipeline stages.
  function automatic int nblk(input int width, input int blk);
    return width / blk;
  endfunction

  // One pipeline stage at the default width: valid bit, carry out of the block
  // resolved so far, partial sum, and the operand bits still to be resolved.
  typedef struct packed {
    logic                      valid;
    logic                      carry;
    logic [CSEL_WIDTH_DEF-1:0] psum;
    logic [CSEL_WIDTH_DEF-1:0] a_hi;
    logic [CSEL_WIDTH_DEF-1:0] bb_hi;
  } stage_t;

endpackage

// File: rtl/csel_adder_pipe_block.sv
// Combinational carry-select block: sums one BLK-bit slice for carry-in 0
// and carry-in 1, and reports the carry into the slice MSB for each case
// (used for signed overflow when CSEL_OVF_EN is defined).
module csel_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  output logic [BLK-1:0] s0_o,
  output logic           c0_o,
  output logic [BLK-1:0] s1_o,
  output logic           c1_o,
  output logic           m0_o,
  output logic           m1_o
);

  assign {c0_o, s0_o} = {1'b0, a_i} + {1'b0, b_i};
  assign {c1_o, s1_o} = {1'b0, a_i} + {1'b0, b_i} + (BLK+1)'(1);

  // The carry into the MSB is recovered from the MSB sum bit and its operands.
  assign m0_o = s0_o[BLK-1] ^ a_i[BLK-1] ^ b_i[BLK-1];
  assign m1_o = s1_o[BLK-1] ^ a_i[BLK-1] ^ b_i[BLK-1];

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor. Stage k resolves operand block k,
// choosing between two precomputed candidates with the carry of stage k-1.
// Each stage has its own valid bit; backpressure propagates through a
// ready chain so that one result per cycle flows at steady state.
// Define CSEL_OVF_EN to add the registered signed-overflow output ovf.
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH_DEF,
  parameter int BLK   = CSEL_BLK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSEL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam bit CFG_OK = (BLK >= 1) && (BLK <= WIDTH) &&
                          ((WIDTH % ((BLK >= 1) ? BLK : 1)) == 0);
  localparam int NBLK   = CFG_OK ? nblk(WIDTH, BLK) : 1;
  localparam int LAST   = NBLK - 1;

  if (!CFG_OK) begin : g_bad_cfg
    $error("csel_adder_pipe: WIDTH must be a multiple of BLK with 1 <= BLK <= WIDTH");
  end

  // Stage record at this instance's width (same fields as csel_pkg::stage_t).
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] bb_hi;
  } stage_w_t;

  stage_w_t         st_q [NBLK];
  stage_w_t         st_d [NBLK];
  stage_w_t         up   [NBLK];
  logic [NBLK-1:0]  rdy;
  logic [WIDTH-1:0] s0_w, s1_w;
  logic [NBLK-1:0]  c0_w, c1_w, m0_w, m1_w;

  // Upstream view of each stage: the accept port for stage 0 (with the
  // effective subtract operands), the previous stage register otherwise.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    up[0].valid = in_valid;
    up[0].carry = cin ^ sub;
    up[0].psum  = '0;
    up[0].a_hi  = a;
    up[0].bb_hi = sub ? ~b : b;
    for (int k = 1; k < NBLK; k++) begin
      up[k] = st_q[k-1];
    end
  end

  // Candidate sums for block k, computed from that stage's upstream operands.
  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    csel_block #(.BLK(BLK)) u_blk (
      .a_i  (up[k].a_hi[k*BLK +: BLK]),
      .b_i  (up[k].bb_hi[k*BLK +: BLK]),
      .s0_o (s0_w[k*BLK +: BLK]),
      .c0_o (c0_w[k]),
      .s1_o (s1_w[k*BLK +: BLK]),
      .c1_o (c1_w[k]),
      .m0_o (m0_w[k]),
      .m1_o (m1_w[k])
    );
  end

  // Ready chain, unrolled: stage k may load if the consumer is ready or any
  // stage from k to the output holds a bubble.
  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      logic r;
      r = out_ready;
      for (int j = k; j < NBLK; j++) begin
        r = r | ~st_q[j].valid;
      end
      rdy[k] = r;
    end
  end

  // Next state of each stage: hold, or load the upstream valid and, when it
  // carries data, the selected block result, its carry and the operands.
  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      st_d[k] = st_q[k];
      if (rdy[k]) begin
        st_d[k].valid = up[k].valid;
        if (up[k].valid) begin
          st_d[k].carry = up[k].carry ? c1_w[k] : c0_w[k];
          st_d[k].psum  = up[k].psum;
          st_d[k].psum[k*BLK +: BLK] = up[k].carry ? s1_w[k*BLK +: BLK]
                                                   : s0_w[k*BLK +: BLK];
          st_d[k].a_hi  = up[k].a_hi;
          st_d[k].bb_hi = up[k].bb_hi;
        end
      end
    end
  end

  // Stage registers; an async reset empties the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data fields are reset along with the valid bits so that
      // sum/cout read as zero out of reset, not just "don't care".
      for (int k = 0; k < NBLK; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples the pre-edge value of its neighbour.
      for (int k = 0; k < NBLK; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = st_q[LAST].valid;
  assign sum       = st_q[LAST].psum;
  assign cout      = st_q[LAST].carry;

`ifdef CSEL_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow = carry into the MSB XOR carry out, captured with the last block.
  always_comb begin
    ovf_d = ovf_q;
    if (rdy[LAST] && up[LAST].valid) begin
      ovf_d = (up[LAST].carry ? m1_w[LAST] : m0_w[LAST]) ^
              (up[LAST].carry ? c1_w[LAST] : c0_w[LAST]);
    end
  end

  // Overflow register, loaded in step with the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  // The last stage's operand copies and the lower-block MSB carries have no consumer.
  logic unused_bits;
  assign unused_bits = ^{m0_w, m1_w, st_q[LAST].a_hi, st_q[LAST].bb_hi};

endmodule
